// File: rtl/mac_exec_unit.sv
// mac_exec_unit: iterative multiply-accumulate unit for the execute stage, stalls the pipeline while busy
module mac_exec_unit #(
  parameter int XLEN       = 32,
  parameter int RADIX_BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_e,
  input  logic            mac_write_e,
  input  logic [1:0]      mac_op_e,
  input  logic [XLEN-1:0] src_a_e,
  input  logic [XLEN-1:0] src_b_e,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] mac_result_o
);
  localparam int N_ITER = XLEN / RADIX_BITS;
  localparam int CW = N_ITER > 1 ? $clog2(N_ITER) : 1;
  localparam logic [1:0] OP_MUL = 2'd1, OP_MACC = 2'd2, OP_CLR = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] a_q, b_q, prod_q, acc_q, term, prod_d, acc_d;
  logic [1:0] op_q;
  logic [CW-1:0] count_q;
  logic [RADIX_BITS-1:0] digit;
  logic [31:0] shamt;
  logic req, clr, last;
  assign req = mac_write_e & ~flush_e & (mac_op_e == OP_MUL | mac_op_e == OP_MACC);
  assign clr = mac_write_e & ~flush_e & mac_op_e == OP_CLR;
  assign last = count_q == CW'(N_ITER - 1);
  assign shamt = 32'(count_q) * RADIX_BITS;
  assign digit = RADIX_BITS'(b_q >> shamt);
  assign term = XLEN'(a_q * XLEN'(digit)) << shamt;
  assign prod_d = prod_q + term;
  assign acc_d = op_q == OP_MACC ? acc_q + prod_d : prod_d;
  assign mac_result_o = acc_q;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  // next state: start on a request, abort on flush, finish after the last digit
  always_comb
    state_d = state_q == S_IDLE ? (req ? S_MUL : S_IDLE) :
              state_q == S_MUL  ? (flush_e ? S_IDLE : last ? S_DONE : S_MUL) : S_IDLE;
  // outputs: stall from the accepting cycle until the last digit, drop on flush or reset
  always_comb begin
    stall_o = ~rst & (state_q == S_IDLE ? req : state_q == S_MUL & ~flush_e);
    done_o = state_q == S_DONE;
  end
  // datapath: latch operands at start, accumulate one digit per cycle, commit on the last digit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      prod_q <= '0;
      count_q <= '0;
      acc_q <= '0;
    end else begin
      if (state_q == S_IDLE & req) begin
        a_q <= src_a_e;
        b_q <= src_b_e;
        op_q <= mac_op_e;
        prod_q <= '0;
        count_q <= '0;
      end else if (state_q == S_MUL) begin
        prod_q <= prod_d;
        count_q <= count_q + 1'b1;
      end
      if (state_q == S_IDLE & clr) acc_q <= '0;
      else if (state_q == S_MUL & ~flush_e & last) acc_q <= acc_d;
    end
endmodule

// File: tb/tb_mac_exec_unit.sv
// tb_mac_exec_unit: random and directed stimulus checked every cycle against a transaction-level model
module tb_mac_exec_unit;
  localparam int XLEN = 32, RB = 8, NI = XLEN / RB;
  logic clk = 0, rst = 1, flush_e = 0, mac_write_e = 0;
  logic [1:0] mac_op_e = 0;
  logic [31:0] src_a_e = 0, src_b_e = 0;
  logic stall_o, done_o;
  logic [31:0] mac_result_o;
  int checks = 0, errors = 0, cyc = 0;
  int left = 0;
  bit in_done = 0;
  logic [31:0] m_acc = 0, m_prod = 0;
  logic [1:0] m_op = 0;
  int done_cnt = 0, last_done = 0, prev_done = 0, stall_cycles = 0;
  logic req;
  always #5 clk = ~clk;
  mac_exec_unit #(.XLEN(XLEN), .RADIX_BITS(RB)) dut (
    .clk(clk), .rst(rst), .flush_e(flush_e), .mac_write_e(mac_write_e), .mac_op_e(mac_op_e),
    .src_a_e(src_a_e), .src_b_e(src_b_e), .stall_o(stall_o), .done_o(done_o), .mac_result_o(mac_result_o)
  );
  assign req = mac_write_e && !flush_e && (mac_op_e == 2'd1 || mac_op_e == 2'd2);
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic mac(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    mac_write_e = 1;
    mac_op_e = op;
    src_a_e = a;
    src_b_e = b;
    repeat (NI + 2) tick;
    mac_write_e = 0;
  endtask
  always @(posedge clk) cyc++;
  // model: an instruction is either idle, multiplying for NI cycles, or reporting done
  always @(posedge clk or posedge rst)
    if (rst) begin
      left = 0;
      in_done = 0;
      m_acc = 0;
    end else if (in_done) in_done = 0;
    else if (left > 0) begin
      if (flush_e) left = 0;
      else begin
        left--;
        if (left == 0) begin
          m_acc = (m_op == 2'd2) ? m_acc + m_prod : m_prod;
          in_done = 1;
        end
      end
    end else if (req) begin
      left = NI;
      m_op = mac_op_e;
      m_prod = src_a_e * src_b_e;
    end else if (mac_write_e && !flush_e && mac_op_e == 2'd3) m_acc = 0;
  always @(negedge clk) begin
    chk("stall_o", 32'(stall_o), 32'(!rst && ((left == 0 && !in_done && req) || (left > 0 && !flush_e))));
    chk("done_o", 32'(done_o), 32'(!rst && in_done));
    chk("mac_result_o", mac_result_o, m_acc);
    if (stall_o) stall_cycles++;
    if (done_o) begin
      prev_done = last_done;
      last_done = cyc;
      done_cnt++;
    end
  end
  initial begin
    int d0;
    logic [31:0] keep;
    repeat (2) tick;
    chk("reset stall", 32'(stall_o), 0);
    chk("reset result", mac_result_o, 0);
    rst = 0;
    tick;
    stall_cycles = 0;
    d0 = done_cnt;
    mac(2'd1, 7, 6);
    chk("mul 7*6", mac_result_o, 42);
    chk("mul stall cycles", stall_cycles, 5);
    chk("mul done pulses", done_cnt - d0, 1);
    mac(2'd2, 3, 5);
    chk("macc 3*5", mac_result_o, 57);
    stall_cycles = 0;
    mac_write_e = 1;
    mac_op_e = 2'd3;
    tick;
    mac_write_e = 0;
    chk("clr result", mac_result_o, 0);
    tick;
    chk("clr no stall", stall_cycles, 0);
    mac(2'd2, 4, 4);
    chk("macc 4*4", mac_result_o, 16);
    mac(2'd1, 57, 1);
    mac(2'd2, 32'hFFFF_FFFF, 2);
    chk("macc wrap", mac_result_o, 32'h37);
    mac_write_e = 1;
    mac_op_e = 2'd1;
    src_a_e = 32'h1234_5678;
    src_b_e = 32'h9ABC_DEF0;
    tick;
    for (int i = 0; i < NI + 1; i++) begin
      src_a_e = $urandom;
      src_b_e = $urandom;
      tick;
    end
    mac_write_e = 0;
    chk("mul big toggled", mac_result_o, 32'h242D_2080);
    keep = mac_result_o;
    d0 = done_cnt;
    mac_write_e = 1;
    mac_op_e = 2'd1;
    src_a_e = 9;
    src_b_e = 9;
    repeat (2) tick;
    flush_e = 1;
    #3;
    chk("flush stall low", 32'(stall_o), 0);
    tick;
    flush_e = 0;
    mac_write_e = 0;
    repeat (NI + 2) tick;
    chk("flush no done", done_cnt - d0, 0);
    chk("flush acc kept", mac_result_o, keep);
    mac_write_e = 1;
    mac_op_e = 2'd1;
    src_a_e = 11;
    src_b_e = 13;
    repeat (2) tick;
    #2;
    rst = 1;
    #1;
    chk("async rst stall", 32'(stall_o), 0);
    chk("async rst result", mac_result_o, 0);
    tick;
    mac_write_e = 0;
    rst = 0;
    tick;
    mac(2'd1, 2, 3);
    chk("b2b first", mac_result_o, 6);
    mac(2'd1, 4, 5);
    chk("b2b second", mac_result_o, 20);
    chk("b2b done spacing", last_done - prev_done, 6);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        mac_write_e = $urandom_range(0, 5) != 0;
        mac_op_e = 2'($urandom_range(0, 3));
        src_a_e = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 300);
        src_b_e = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 300);
      end
      flush_e = $urandom_range(0, 15) == 0;
      tick;
    end
    flush_e = 0;
    mac_write_e = 0;
    repeat (3) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
